// File: rtl/loader_pkg.sv
// Shared types and widths for the image loader: FSM state encoding and the
// byte/word/address geometry of the data-memory lane word.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } loader_state_t;

    localparam int LANES  = 8;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 64;
    localparam int ADDR_W = 16;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler: the first accepted byte lands in lane 0,
// the eighth in lane 7, after which the lane counter wraps for the next word.
import loader_pkg::*;

module byte_packer (
    input  logic              clk,
    input  logic              reset,
    input  logic              accept,
    input  logic              clear,
    input  logic [BYTE_W-1:0] data_byte,
    output logic [WORD_W-1:0] word,
    output logic              last_lane
);

    localparam int LANE_W = $clog2(LANES);

    logic [LANE_W-1:0] lane;
    logic [WORD_W-1:0] word_reg;

    // Lanes are only overwritten, never cleared per word, so the completed word
    // stays intact on the outputs through the following write cycle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lane     <= '0;
            word_reg <= '0;
        end else if (accept) begin
            for (int k = 0; k < LANES; k++) begin
                if (lane == LANE_W'(k)) begin
                    word_reg[k*BYTE_W +: BYTE_W] <= data_byte;
                end
            end
            lane <= lane + LANE_W'(1);
        end
    end

    assign word      = word_reg;
    assign last_lane = (lane == LANE_W'(LANES - 1));

endmodule

// File: rtl/image_loader.sv
// Streams host bytes into 64-bit data-memory words and stalls the core until the
// image is loaded. Define LOADER_CHECKSUM_EN to build the running byte checksum.
import loader_pkg::*;

module image_loader #(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0]       NUM_WORDS = 16'd1024,
    parameter logic [ADDR_W-1:0] ADDR_STEP = 16'd1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic [15:0]       words_written,
    output logic [15:0]       checksum
);

    loader_state_t     state;
    loader_state_t     next_state;
    logic [ADDR_W-1:0] addr;
    logic              accept;
    logic              start_load;
    logic              last_lane;
    logic              last_word;

    assign accept     = byte_valid && byte_ready;
    assign start_load = start && ((state == IDLE) || (state == DONE));
    assign last_word  = (words_written + 16'd1) == NUM_WORDS;

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .accept    (accept),
        .clear     (start_load),
        .data_byte (byte_data),
        .word      (mem_wdata),
        .last_lane (last_lane)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        core_hold  = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = FILL;
            end
            FILL: begin
                byte_ready = 1'b1;
                if (accept && last_lane) next_state = WRITE;
            end
            WRITE: begin
                mem_we     = 1'b1;
                next_state = last_word ? DONE : FILL;
            end
            DONE: begin
                done      = 1'b1;
                core_hold = 1'b0;
                if (start) next_state = FILL;
            end
            default: next_state = IDLE;
        endcase
    end

    // Address wraps silently at 16 bits; a restart rewinds it to BASE_ADDR.
    always_ff @(posedge clk) begin
        if (reset || start_load) begin
            addr          <= BASE_ADDR;
            words_written <= '0;
        end else if (state == WRITE) begin
            addr          <= addr + ADDR_STEP;
            words_written <= words_written + 16'd1;
        end
    end

    assign mem_addr = addr;

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] sum;

    always_ff @(posedge clk) begin
        if (reset || start_load) begin
            sum <= '0;
        end else if (accept) begin
            sum <= sum + {8'h00, byte_data};
        end
    end

    assign checksum = sum;
`else
    assign checksum = 16'h0000;
`endif

endmodule
